// File: rtl/deck_reader_if.sv
// Bus bundle for the deck reader: the deck RAM read port and the card stream
// toward the dealer logic.
interface deck_reader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic [DATA_W-1:0] ram_data;
  logic              card_valid;
  logic              card_ready;
  logic [DATA_W-1:0] card_value;

  modport master (
    output ram_addr, ram_wr_en, card_valid, card_value,
    input  ram_data, card_ready
  );

  modport slave (
    input  ram_addr, ram_wr_en, card_valid, card_value,
    output ram_data, card_ready
  );
endinterface

// File: rtl/deck_reader.sv
// Fetches the shuffled deck from RAM one card at a time and presents each card
// on a valid/ready stream, counting cards left and flagging an exhausted deck.
module deck_reader #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 4,
  parameter int DECK_SIZE   = 52,
  parameter int BASE_ADDR   = 0,
  parameter int RAM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  deck_reader_if.master   bus,
  output logic [ADDR_W:0] cards_left,
  output logic            deck_empty,
  output logic            busy
);

  localparam int WCW = $clog2(RAM_LATENCY + 2);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DECK = (ADDR_W+1)'(DECK_SIZE);
  localparam logic [WCW-1:0]    LAT  = WCW'(RAM_LATENCY);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    EMPTY   = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WCW-1:0]    wait_cnt;

  assign bus.ram_wr_en = 1'b0;

  // Deck-walk FSM; start overrides every state, including a pending handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= BASE;
      wait_cnt       <= '0;
      bus.ram_addr   <= BASE;
      bus.card_valid <= 1'b0;
      bus.card_value <= '0;
      cards_left     <= '0;
      deck_empty     <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      state          <= FETCH;
      ptr            <= BASE;
      wait_cnt       <= '0;
      bus.card_valid <= 1'b0;
      cards_left     <= DECK;
      deck_empty     <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
        end
        FETCH: begin
          bus.ram_addr <= ptr;
          wait_cnt     <= '0;
          state        <= WAIT;
        end
        // The first WAIT edge is where the RAM samples the new address.
        WAIT: begin
          if (wait_cnt == LAT) begin
            bus.card_value <= bus.ram_data;
            bus.card_valid <= 1'b1;
            state          <= PRESENT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        PRESENT: begin
          if (bus.card_ready) begin
            bus.card_valid <= 1'b0;
            ptr            <= ptr + ADDR_W'(1);
            cards_left     <= cards_left - (ADDR_W+1)'(1);
            if (cards_left == (ADDR_W+1)'(1)) begin
              deck_empty <= 1'b1;
              busy       <= 1'b0;
              state      <= EMPTY;
            end else begin
              state <= FETCH;
            end
          end
        end
        EMPTY: begin
          bus.card_valid <= 1'b0;
          deck_empty     <= 1'b1;
          busy           <= 1'b0;
        end
        default: begin
          bus.card_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
